// File: rtl/uu_acmac_mem_pkg.sv
// -----------------------------------------------------------------------------
// uu_acmac_mem_pkg
// Shared definitions for the LMAC TX control memory:
//   - mem_state_e : clear-sequence FSM state encoding
//   - RD_LAT_MIN / RD_LAT_MAX : legal bounds of the read latency parameter
// -----------------------------------------------------------------------------
package uu_acmac_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/uu_acmac_mem_rd_pipe.sv
// -----------------------------------------------------------------------------
// uu_acmac_mem_rd_pipe
// Read-data output pipeline for one memory port. Stage 1 always exists; a
// second stage is added when RD_LAT is 2. Both stages clear synchronously.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset
//   i_data  in   DATA_W  stage-1 load value (already zeroed for idle/illegal)
//   o_data  out  DATA_W  read data after RD_LAT edges
// -----------------------------------------------------------------------------
module uu_acmac_mem_rd_pipe
    import uu_acmac_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_stage1;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge value of its source, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage1 <= '0;
        end else begin
            r_stage1 <= i_data;
        end
    end

    generate
        if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
            logic [DATA_W-1:0] r_stage2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stage2 <= '0;
                end else begin
                    r_stage2 <= r_stage1;
                end
            end

            assign o_data = r_stage2;
        end else begin : g_lat1
            assign o_data = r_stage1;
        end
    endgenerate

endmodule

// File: rtl/uu_acmac_mem_tx_ctrl_dp.sv
// -----------------------------------------------------------------------------
// uu_acmac_mem_tx_ctrl_dp
// Dual-port TX control memory. Port A serves the TX control engine, port B the
// host/config side. After reset a hardware sequence zeroes every entry before
// the ports are honoured. Out-of-range accesses are dropped and flagged; a
// same-address write on both ports keeps port A's data and is flagged.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_a_in_en/wen/addr/data port A request (wen=1 write, 0 read)
//   mem_a_out_data            port A read data, RD_LAT edges after request
//   mem_b_in_en/wen/addr/data port B request
//   mem_b_out_data            port B read data
//   mem_init_done             high once the clear sequence has finished
//   mem_addr_err              1-cycle pulse on any out-of-range access
//   mem_collision             1-cycle pulse on a same-address dual write
// -----------------------------------------------------------------------------
module uu_acmac_mem_tx_ctrl_dp
    import uu_acmac_mem_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 301,
    parameter int ADDR_W  = 9,
    parameter int RD_LAT  = 1,
    parameter int RDW_NEW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_a_in_en,
    input  logic              mem_a_in_wen,
    input  logic [ADDR_W-1:0] mem_a_in_addr,
    input  logic [DATA_W-1:0] mem_a_in_data,
    output logic [DATA_W-1:0] mem_a_out_data,
    input  logic              mem_b_in_en,
    input  logic              mem_b_in_wen,
    input  logic [ADDR_W-1:0] mem_b_in_addr,
    input  logic [DATA_W-1:0] mem_b_in_data,
    output logic [DATA_W-1:0] mem_b_out_data,
    output logic              mem_init_done,
    output logic              mem_addr_err,
    output logic              mem_collision
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Clear-sequence FSM
    // ------------------------------------------------------------------
    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;
    logic              w_clr_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_clr_we      = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_ptr == LP_LAST) begin
                    w_state_nxt   = READY;
                    w_clr_ptr_nxt = '0;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
                end
            end
            READY:   w_state_nxt = READY;
            default: w_state_nxt = CLEAR;
        endcase
    end

    // READY is entered on the edge after the last clear write.
    assign mem_init_done = (r_state == READY);

    // ------------------------------------------------------------------
    // Port decode; accesses are only honoured in READY and outside reset
    // ------------------------------------------------------------------
    logic w_ready;
    logic w_a_in_rng, w_a_acc, w_a_we, w_a_err;
    logic w_b_in_rng, w_b_acc, w_b_we, w_b_err;
    logic w_same_addr, w_coll, w_b_we_eff;

    assign w_ready     = (r_state == READY) && !rst;

    assign w_a_in_rng  = ({1'b0, mem_a_in_addr} < LP_DEPTH);
    assign w_a_acc     = w_ready && mem_a_in_en;
    assign w_a_we      = w_a_acc && mem_a_in_wen && w_a_in_rng;
    assign w_a_err     = w_a_acc && !w_a_in_rng;

    assign w_b_in_rng  = ({1'b0, mem_b_in_addr} < LP_DEPTH);
    assign w_b_acc     = w_ready && mem_b_in_en;
    assign w_b_we      = w_b_acc && mem_b_in_wen && w_b_in_rng;
    assign w_b_err     = w_b_acc && !w_b_in_rng;

    // Only in-range writes reach w_*_we, so dropped writes never collide.
    assign w_same_addr = (mem_a_in_addr == mem_b_in_addr);
    assign w_coll      = w_a_we && w_b_we && w_same_addr;
    assign w_b_we_eff  = w_b_we && !w_coll;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto RAM macros; its
    // contents are zeroed by the CLEAR sequence instead.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_ptr] <= '0;
        end
        if (w_a_we) begin
            r_mem[mem_a_in_addr] <= mem_a_in_data;
        end
        if (w_b_we_eff) begin
            r_mem[mem_b_in_addr] <= mem_b_in_data;
        end
    end

    // Stage-1 load values. The array read sees pre-edge contents, which
    // gives old data for cross-port read-during-write and for RDW_NEW = 0.
    logic [DATA_W-1:0] w_a_rd, w_b_rd;

    always_comb begin
        w_a_rd = '0;
        if (w_a_acc && w_a_in_rng) begin
            if (mem_a_in_wen && (RDW_NEW != 0)) begin
                w_a_rd = mem_a_in_data;
            end else begin
                w_a_rd = r_mem[mem_a_in_addr];
            end
        end
    end

    always_comb begin
        w_b_rd = '0;
        if (w_b_acc && w_b_in_rng) begin
            if (mem_b_in_wen && (RDW_NEW != 0)) begin
                w_b_rd = mem_b_in_data;
            end else begin
                w_b_rd = r_mem[mem_b_in_addr];
            end
        end
    end

    uu_acmac_mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe_a (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_a_rd),
        .o_data (mem_a_out_data)
    );

    uu_acmac_mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe_b (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_b_rd),
        .o_data (mem_b_out_data)
    );

    // ------------------------------------------------------------------
    // Status pulses: always one edge after the request, independent of RD_LAT
    // ------------------------------------------------------------------
    logic r_addr_err;
    logic r_collision;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_err  <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_addr_err  <= w_a_err || w_b_err;
            r_collision <= w_coll;
        end
    end

    assign mem_addr_err  = r_addr_err;
    assign mem_collision = r_collision;

endmodule

// File: tb/tb_uu_acmac_mem_tx_ctrl_dp.sv
// -----------------------------------------------------------------------------
// tb_uu_acmac_mem_tx_ctrl_dp
// Two instances share all inputs: dut0 (RD_LAT=1, RDW_NEW=0) and
// dut1 (RD_LAT=2, RDW_NEW=1). The driver issues directed requests and queues
// the hand-computed response for the cycle it must appear; the monitor pops
// and compares entries as their cycle comes up.
// -----------------------------------------------------------------------------
module tb_uu_acmac_mem_tx_ctrl_dp;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 301;
    localparam int ADDR_W = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              a_en, a_wen, b_en, b_wen;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic [DATA_W-1:0] a_q0, b_q0, a_q1, b_q1;
    logic              done0, done1, err0, err1, col0, col1;

    uu_acmac_mem_tx_ctrl_dp #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1), .RDW_NEW(0)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .mem_a_in_en(a_en), .mem_a_in_wen(a_wen), .mem_a_in_addr(a_addr),
        .mem_a_in_data(a_data), .mem_a_out_data(a_q0),
        .mem_b_in_en(b_en), .mem_b_in_wen(b_wen), .mem_b_in_addr(b_addr),
        .mem_b_in_data(b_data), .mem_b_out_data(b_q0),
        .mem_init_done(done0), .mem_addr_err(err0), .mem_collision(col0)
    );

    uu_acmac_mem_tx_ctrl_dp #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2), .RDW_NEW(1)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .mem_a_in_en(a_en), .mem_a_in_wen(a_wen), .mem_a_in_addr(a_addr),
        .mem_a_in_data(a_data), .mem_a_out_data(a_q1),
        .mem_b_in_en(b_en), .mem_b_in_wen(b_wen), .mem_b_in_addr(b_addr),
        .mem_b_in_data(b_data), .mem_b_out_data(b_q1),
        .mem_init_done(done1), .mem_addr_err(err1), .mem_collision(col1)
    );

    typedef enum int {
        K_A0, K_B0, K_A1, K_B1, K_ERR0, K_ERR1, K_COL0, K_COL1, K_DONE0, K_DONE1
    } kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [7:0]  val;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_mis  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Insert keeping the queue ordered by due cycle.
    function automatic void expect_at(input int c, input kind_e k, input logic [7:0] v);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        i = 0;
        while (i < sb_q.size() && sb_q[i].cyc <= c) i++;
        sb_q.insert(i, e);
    endfunction

    function automatic logic [7:0] actual(input kind_e k);
        case (k)
            K_A0:    return a_q0;
            K_B0:    return b_q0;
            K_A1:    return a_q1;
            K_B1:    return b_q1;
            K_ERR0:  return {7'b0, err0};
            K_ERR1:  return {7'b0, err1};
            K_COL0:  return {7'b0, col0};
            K_COL1:  return {7'b0, col1};
            K_DONE0: return {7'b0, done0};
            default: return {7'b0, done1};
        endcase
    endfunction

    task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got 0x%02h, expected 0x%02h", name, c, act, exp_v);
        end
    endtask

    // Monitor: sample 1 time unit after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.cyc < cyc) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL stale_%s due cyc %0d seen at cyc %0d", e.kind.name(), e.cyc, cyc);
                end else begin
                    check(e.kind.name(), e.cyc, actual(e.kind), e.val);
                end
            end
        end
    end

    // One request cycle; expected dut0 data at +1, dut1 data at +2, flags at +1.
    task automatic drive(
        input logic ae, input logic aw, input logic [8:0] aa, input logic [7:0] ad,
        input logic be, input logic bw, input logic [8:0] ba, input logic [7:0] bd,
        input logic [7:0] ea0, input logic [7:0] eb0,
        input logic [7:0] ea1, input logic [7:0] eb1,
        input logic er, input logic co
    );
        @(negedge clk);
        a_en = ae; a_wen = aw; a_addr = aa; a_data = ad;
        b_en = be; b_wen = bw; b_addr = ba; b_data = bd;
        expect_at(cyc + 1, K_A0, ea0);
        expect_at(cyc + 1, K_B0, eb0);
        expect_at(cyc + 2, K_A1, ea1);
        expect_at(cyc + 2, K_B1, eb1);
        expect_at(cyc + 1, K_ERR0, {7'b0, er});
        expect_at(cyc + 1, K_ERR1, {7'b0, er});
        expect_at(cyc + 1, K_COL0, {7'b0, co});
        expect_at(cyc + 1, K_COL1, {7'b0, co});
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b0, 1'b0, 9'd0, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic nop();
        @(negedge clk);
        a_en = 1'b0; a_wen = 1'b0; b_en = 1'b0; b_wen = 1'b0;
    endtask

    task automatic expect_done(input int c, input logic v);
        expect_at(c, K_DONE0, {7'b0, v});
        expect_at(c, K_DONE1, {7'b0, v});
    endtask

    // Two reset edges, release on the following negedge; returns release cycle.
    task automatic do_reset(output int r);
        @(negedge clk);
        rst = 1'b1;
        a_en = 1'b0; a_wen = 1'b0; b_en = 1'b0; b_wen = 1'b0;
        expect_done(cyc + 1, 1'b0);
        nop();
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int r_rel;
    int guard;

    initial begin
        rst = 1'b1;
        a_en = 1'b0; a_wen = 1'b0; a_addr = '0; a_data = '0;
        b_en = 1'b0; b_wen = 1'b0; b_addr = '0; b_data = '0;
        nop();
        nop();

        // Reset state: outputs 0 while rst is held
        expect_done(cyc + 1, 1'b0);
        idle();
        idle();
        @(negedge clk);
        rst = 1'b0;
        r_rel = cyc;
        expect_done(r_rel + 300, 1'b0);
        expect_done(r_rel + 301, 1'b1);

        // Accesses during CLEAR are ignored: no write, zero data, no flags
        repeat (9) nop();
        drive(1'b1, 1'b1, 9'd5,   8'h77, 1'b1, 1'b0, 9'd5,   8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 9'd400, 8'h00, 1'b1, 1'b1, 9'd511, 8'h33,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 9'd7,   8'h44, 1'b1, 1'b1, 9'd7,   8'h55,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        while (cyc < r_rel + 301) nop();

        // Cleared contents, including boundary 300 and the ignored writes
        drive(1'b1, 1'b0, 9'd0,   8'h00, 1'b1, 1'b0, 9'd0,   8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 9'd150, 8'h00, 1'b1, 1'b0, 9'd300, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 9'd5,   8'h00, 1'b1, 1'b0, 9'd7,   8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Write 0x5A to 10; B reads the old value in the same cycle
        drive(1'b1, 1'b1, 9'd10, 8'h5A, 1'b1, 1'b0, 9'd10, 8'h00,
              8'h00, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 9'd10, 8'h00, 1'b0, 1'b0, 9'd0,  8'h00,
              8'h5A, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 9'd10, 8'hA5, 1'b1, 1'b0, 9'd10, 8'h00,
              8'h5A, 8'h5A, 8'hA5, 8'h5A, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 1'b0, 9'd10, 8'h00,
              8'h00, 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0);
        idle();

        // Same-address dual write: A wins, single collision pulse
        drive(1'b1, 1'b1, 9'd20, 8'h11, 1'b1, 1'b1, 9'd20, 8'h22,
              8'h00, 8'h00, 8'h11, 8'h22, 1'b0, 1'b1);
        idle();
        drive(1'b1, 1'b0, 9'd20, 8'h00, 1'b1, 1'b0, 9'd20, 8'h00,
              8'h11, 8'h11, 8'h11, 8'h11, 1'b0, 1'b0);

        // Out-of-range accesses
        drive(1'b0, 1'b0, 9'd0,   8'h00, 1'b1, 1'b1, 9'd301, 8'hFF,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        idle();
        drive(1'b0, 1'b0, 9'd0,   8'h00, 1'b1, 1'b0, 9'd511, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 9'd0,   8'h00, 1'b1, 1'b0, 9'd300, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 9'd301, 8'h12, 1'b1, 1'b1, 9'd301, 8'h34,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 9'd301, 8'h00, 1'b0, 1'b0, 9'd0,   8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

        // Last valid index is writable
        drive(1'b1, 1'b1, 9'd300, 8'h3C, 1'b1, 1'b0, 9'd300, 8'h00,
              8'h00, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 9'd300, 8'h00, 1'b0, 1'b0, 9'd0,   8'h00,
              8'h3C, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0);
        idle();
        idle();

        // Reset from READY, then again at clear cycle 100
        do_reset(r_rel);
        expect_done(r_rel + 50, 1'b0);
        while (cyc < r_rel + 100) nop();
        do_reset(r_rel);
        expect_done(r_rel + 1,   1'b0);
        expect_done(r_rel + 300, 1'b0);
        expect_done(r_rel + 301, 1'b1);
        while (cyc < r_rel + 301) nop();
        drive(1'b1, 1'b0, 9'd10,  8'h00, 1'b1, 1'b0, 9'd20, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 9'd300, 8'h00, 1'b1, 1'b0, 9'd5,  8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        idle();

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: %0d expectations never reached", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/uu_acmac_mem_tx_ctrl_dp.md
Name: uu_acmac_mem_tx_ctrl_dp

Overview:
Parametrised dual-port TX control memory for the LMAC TX path. Port A serves the TX control engine and port B serves the host/config side. Adds four things:
- a hardware clear sequence after reset
- out-of-range address protection
- a selectable read latency
- defined same-address collision handling

It replaces the fixed 8-bit, 301-entry single-port TX control memory in testbench and RTL builds.

Parameters:
DATA_W, 8, data width in bits
DEPTH, 301, number of valid entries (indices 0..DEPTH-1)
ADDR_W, 9, address width; must satisfy 2**ADDR_W >= DEPTH
RD_LAT, 1, read latency in cycles; legal values 1 or 2
RDW_NEW, 0, same-port write read-back: 0 returns old data, 1 returns written data

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_a_in_en  in  1  port A enable
mem_a_in_wen  in  1  port A: 1 = write, 0 = read (enable required)
mem_a_in_addr  in  ADDR_W  port A address
mem_a_in_data  in  DATA_W  port A write data
mem_a_out_data  out  DATA_W  port A read data
mem_b_in_en  in  1  port B enable
mem_b_in_wen  in  1  port B write/read select
mem_b_in_addr  in  ADDR_W  port B address
mem_b_in_data  in  DATA_W  port B write data
mem_b_out_data  out  DATA_W  port B read data
mem_init_done  out  1  high once the clear sequence has completed
mem_addr_err  out  1  one-cycle pulse on any out-of-range access, either port
mem_collision  out  1  one-cycle pulse when A and B write the same address in the same cycle

Behaviour:
- Reset: while rst is high, all outputs are 0 and the pipeline registers are 0. The FSM goes to CLEAR with clr_ptr = 0.
- FSM state CLEAR:
  - Writes 0 to entry clr_ptr each cycle and increments clr_ptr.
  - On the cycle that writes DEPTH-1, moves to READY and sets mem_init_done to 1 on the next edge.
  - The clear takes exactly DEPTH cycles after rst is released.
  - All port accesses are ignored in CLEAR: no write occurs, read data is 0, and no err or collision pulse is raised.
- FSM state READY: normal operation.
  - rst asserted in any state returns the FSM to CLEAR, drops mem_init_done and restarts the clear at index 0.
  - rst asserted mid-clear restarts the clear from 0.
- Per-port access in READY (A and B identical):
  - en = 0: the port's stage-1 data register loads 0.
  - en = 1, wen = 0: stage-1 loads mem[addr].
  - en = 1, wen = 1: mem[addr] <= data. Stage-1 loads old mem[addr] if RDW_NEW = 0, or data if RDW_NEW = 1.
- Latency:
  - RD_LAT = 1: out_data is the stage-1 register, valid on the edge after the request.
  - RD_LAT = 2: one further register stage follows; out_data is valid two edges after the request.
  - The pipeline advances every cycle; there is no stall.
- Out-of-range address (addr >= DEPTH, en = 1):
  - The write is dropped.
  - Read data is 0.
  - mem_addr_err pulses high on the edge after the request, regardless of RD_LAT.
- Cross-port read during write, different ports, same address: the reading port returns the old data.
- Same-address write on both ports:
  - Port A's data is stored.
  - mem_collision pulses on the edge after the request.
  - Each port's read-back follows the RDW_NEW rule using its own data.
- Out-of-range writes on both ports never count as a collision.
- Storage is DEPTH x DATA_W with no reset of its contents; it is zeroed only by the CLEAR sequence.

Decomposition:
- Package uu_acmac_mem_pkg holds:
  - FSM state encoding: CLEAR = 1'b0, READY = 1'b1
  - constants RD_LAT_MIN = 1 and RD_LAT_MAX = 2
- One natural sub-module, uu_acmac_mem_rd_pipe:
  - parametrised by DATA_W and RD_LAT
  - instantiated once per port
  - implements the output register stage(s) with synchronous clear.
- Storage, the clear FSM and the collision/error logic stay in the top module.

Test Plan:
1. Release rst, then read address 0, 150 and 300 on both ports after mem_init_done rises. mem_init_done rises exactly 301 cycles after release, and all reads return 0x00.
2. Port A writes 0x5A to address 10, then reads it with RD_LAT = 1 and again with RD_LAT = 2. Read-back 0x5A appears 1 and 2 cycles after the read respectively. With RDW_NEW = 0 the write cycle itself returns the old 0x00; with RDW_NEW = 1 it returns 0x5A.
3. In the same cycle, A writes 0x11 and B writes 0x22 to address 20. mem_collision pulses for one cycle, and a subsequent read of address 20 returns 0x11.
4. Port B writes 0xFF to address 301, then reads address 511. mem_addr_err pulses on each access, reads return 0, and a read of address 300 is still 0x00.
5. Assert rst at clear cycle 100, then release it. mem_init_done stays 0 for 301 cycles after release, and a location written before the reset reads 0x00 afterwards.
6. Issue accesses during CLEAR: write 0x77 to address 5 on A while the clear is still running. No write takes effect, no error pulse is raised, and address 5 reads 0x00 after mem_init_done rises.
